// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM sequencing one instruction through fetch/decode/execute/memory/writeback.
// Define FPU_WDOG_EN to add the FPUWAIT watchdog (FPU_WDOG_CYCLES) and the sticky FpuErr flag.
module multicycle_ctrl_fsm #(
  parameter int FPU_WDOG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FpuDone,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       FPUOp,
  output logic       FPUStart,
  output logic       FpuErr,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_FPUSTART = 4'd10;
  localparam logic [3:0] S_FPUWAIT  = 4'd11;
  localparam logic [3:0] S_FPUWB    = 4'd12;

  if ((FPU_WDOG_CYCLES < 2) || (FPU_WDOG_CYCLES > 255)) begin : g_bad_wdog_cycles
    $error("FPU_WDOG_CYCLES must lie in 2..255");
  end

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic       wdog_timeout;

  // Funct[4:1] belong to the ALU/FPU decode beside this block, not to sequencing.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FPUSTART;
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_FPUSTART: state_next = S_FPUWAIT;
      S_FPUWAIT: begin
        // A done arriving together with the timeout still completes normally.
        if (FpuDone) begin
          state_next = S_FPUWB;
        end else if (wdog_timeout) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_FPUWAIT;
        end
      end
      default:    state_next = S_FETCH;
    endcase
  end

  logic ir_write_dec;
  logic next_pc_dec;
  logic reg_w_dec;
  logic mem_w_dec;
  logic branch_dec;
  logic fpu_start_dec;

  always_comb begin
    ir_write_dec  = 1'b0;
    next_pc_dec   = 1'b0;
    reg_w_dec     = 1'b0;
    mem_w_dec     = 1'b0;
    branch_dec    = 1'b0;
    fpu_start_dec = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUOp         = 1'b0;
    FPUOp         = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write_dec = 1'b1;
        next_pc_dec  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_dec = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_dec = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB:    reg_w_dec = 1'b1;
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_dec = 1'b1;
      end
      S_FPUSTART: begin
        FPUOp         = 1'b1;
        fpu_start_dec = 1'b1;
      end
      S_FPUWAIT:  FPUOp = 1'b1;
      S_FPUWB: begin
        FPUOp     = 1'b1;
        ResultSrc = 2'b11;
        reg_w_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are masked by the reset level itself so nothing fires between
  // assertion and the asynchronous state clear taking effect downstream.
  assign IRWrite  = ir_write_dec  & reset;
  assign NextPC   = next_pc_dec   & reset;
  assign RegW     = reg_w_dec     & reset;
  assign MemW     = mem_w_dec     & reset;
  assign Branch   = branch_dec    & reset;
  assign FPUStart = fpu_start_dec & reset;
  assign State    = state_reg;

`ifdef FPU_WDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(FPU_WDOG_CYCLES - 1);

  logic [7:0] wdog_cnt_reg;
  logic       fpu_err_reg;

  // Count equals the number of FPUWAIT cycles already completed.
  assign wdog_timeout = (state_reg == S_FPUWAIT) && !FpuDone && (wdog_cnt_reg == WDOG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_reg <= 8'd0;
      fpu_err_reg  <= 1'b0;
    end else begin
      if (state_reg == S_FPUSTART) begin
        wdog_cnt_reg <= 8'd0;
      end else if (state_reg == S_FPUWAIT) begin
        wdog_cnt_reg <= wdog_cnt_reg + 8'd1;
      end
      if (wdog_timeout) begin
        fpu_err_reg <= 1'b1;
      end
    end
  end

  assign FpuErr = fpu_err_reg;
`else
  assign wdog_timeout = 1'b0;
  assign FpuErr       = 1'b0;
`endif

endmodule
